// File: rtl/ctrl_unit_mc.sv
// ctrl_unit_mc: multi-cycle MIPS-style control FSM with variable memory latency and exceptions
module ctrl_unit_mc #(
    parameter int MEM_LAT = 1,
    parameter bit EXC_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       overflow,
    input  logic       zero,
    output logic       pc_write,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       epc_write,
    output logic [1:0] exc_cause,
    output logic [5:0] state
);
    typedef enum logic [5:0] {
        S_RESET    = 6'd0,
        S_FETCH    = 6'd1,
        S_DECODE   = 6'd2,
        S_EXEC_R   = 6'd3,
        S_WB_R     = 6'd4,
        S_EXEC_I   = 6'd5,
        S_WB_I     = 6'd6,
        S_MEM_ADDR = 6'd7,
        S_MEM_RD   = 6'd8,
        S_WB_LW    = 6'd9,
        S_MEM_WR   = 6'd10,
        S_BRANCH   = 6'd11,
        S_JUMP     = 6'd12,
        S_EXC      = 6'd13
    } state_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] cause_q, cause_d;
    logic       last, f_add, f_sub, f_and;

    assign last      = cnt_q == LAST;
    assign f_add     = funct == 6'h20;
    assign f_sub     = funct == 6'h22;
    assign f_and     = funct == 6'h24;
    assign state     = state_q;
    assign exc_cause = cause_q;
    // the wait counter restarts on every state change, so each wait state begins at zero
    assign cnt_d     = (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;

    // state, wait counter and exception cause registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RESET;
            cnt_q   <= 4'd0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // next-state, cause capture and control outputs decoded from the current state
    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        epc_write  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write  = last;
                pc_write  = last;
                alu_src_b = last ? 2'b01 : 2'b00;
                state_d   = last ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'h00:        state_d = S_EXEC_R;
                    6'h08:        state_d = S_EXEC_I;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        state_d = EXC_EN ? S_EXC : S_FETCH;
                        cause_d = EXC_EN ? 2'b01 : cause_q;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = f_sub ? 3'b001 : f_and ? 3'b010 : 3'b000;
                if (!(f_add || f_sub || f_and)) begin
                    state_d = EXC_EN ? S_EXC : S_FETCH;
                    cause_d = EXC_EN ? 2'b01 : cause_q;
                end else if ((f_add || f_sub) && overflow && EXC_EN) begin
                    state_d = S_EXC;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_WB_R;
                end
            end
            S_WB_R: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (overflow && EXC_EN) ? S_EXC : S_WB_I;
                cause_d   = (overflow && EXC_EN) ? 2'b10 : cause_q;
            end
            S_WB_I: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                iord    = 1'b1;
                state_d = last ? S_WB_LW : S_MEM_RD;
            end
            S_WB_LW: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = last ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_source = 2'b01;
                pc_write  = (opcode == 6'h04) ? zero : ~zero;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                state_d   = S_FETCH;
            end
            S_EXC: begin
                epc_write = 1'b1;
                alu_src_b = 2'b01;
                alu_op    = 3'b001;
                pc_write  = 1'b1;
                pc_source = 2'b11;
                state_d   = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end
endmodule
